// File: rtl/chan_fifo_writer_pkg.sv
// Shared definitions for the channel FIFO writer and reader: header bit layout,
// writer FSM state encoding and the QI16 sample packing.
package chan_fifo_writer_pkg;

   localparam int unsigned HdrOverrunBit = 31;
   localparam int unsigned HdrSobBit     = 28;
   localparam int unsigned HdrEobBit     = 27;
   localparam int unsigned HdrRssiHi     = 23;
   localparam int unsigned HdrRssiLo     = 16;
   localparam int unsigned HdrLenHi      = 8;
   localparam int unsigned HdrLenLo      = 2;

   typedef enum logic [3:0] {
      StIdle      = 4'd0,
      StHeader    = 4'd1,
      StTimestamp = 4'd2,
      StSamples   = 4'd3,
      StPad       = 4'd4,
      StEobHdr    = 4'd5,
      StEobTs     = 4'd6
   } state_e;

   // QI16 sample word: Q in the upper half, I in the lower half.
   function automatic logic [31:0] pack_qi16(input logic [15:0] q, input logic [15:0] i);
      return {q, i};
   endfunction

endpackage

// File: rtl/chan_fifo_writer_if.sv
// Sample input, FIFO write and status signals of one receive channel.
interface chan_fifo_writer_if;
   logic        rx_enable;
   logic        rx_strobe;
   logic [15:0] rx_i;
   logic [15:0] rx_q;
   logic [31:0] timestamp_clock;
   logic [31:0] rssi;
   logic [7:0]  fifo_space;
   logic [31:0] fifodata;
   logic        wrreq;
   logic        overrun;
   logic [14:0] debug;

   modport master (
      output rx_enable, rx_strobe, rx_i, rx_q, timestamp_clock, rssi, fifo_space,
      input  fifodata, wrreq, overrun, debug
   );

   modport slave (
      input  rx_enable, rx_strobe, rx_i, rx_q, timestamp_clock, rssi, fifo_space,
      output fifodata, wrreq, overrun, debug
   );
endinterface

// File: rtl/chan_fifo_writer_hdr_build.sv
// Combinational packet header assembly from flags, payload length and rssi.
module chan_hdr_build
   import chan_fifo_writer_pkg::*;
(
   input  logic        i_overrun,
   input  logic        i_sob,
   input  logic        i_eob,
   input  logic [6:0]  i_len,
   input  logic [7:0]  i_rssi,
   output logic [31:0] o_hdr
);

   always_comb begin
      o_hdr                       = '0;
      o_hdr[HdrOverrunBit]        = i_overrun;
      o_hdr[HdrSobBit]            = i_sob;
      o_hdr[HdrEobBit]            = i_eob;
      o_hdr[HdrRssiHi:HdrRssiLo]  = i_rssi;
      o_hdr[HdrLenHi:HdrLenLo]    = i_len;
   end

endmodule

// File: rtl/chan_fifo_writer.sv
// Frames decimated rx samples into header/timestamp/payload packets for the
// per-channel FIFO, with burst start/end markers and sticky overrun reporting.
module chan_fifo_writer
   import chan_fifo_writer_pkg::*;
#(
   parameter int unsigned PAYLOAD_WORDS = 126
) (
   input  logic              i_rx_clock,
   input  logic              i_reset,
   chan_fifo_writer_if.slave bus
);

   localparam logic [6:0] PayloadLen = 7'(PAYLOAD_WORDS);
   localparam logic [8:0] NeedSpace  = 9'(PAYLOAD_WORDS + 2);

   state_e      r_state;
   logic [31:0] r_fifodata;
   logic [31:0] r_hold;
   logic [31:0] r_ts_latch;
   logic        r_wrreq;
   logic        r_overrun;
   logic        r_burst;
   logic        r_eob_pending;
   logic [6:0]  r_word_cnt;

   logic [31:0] w_pkt_hdr;
   logic [31:0] w_eob_hdr;
   logic        w_has_room;
   logic        w_unused_rssi;

   assign w_has_room    = {1'b0, bus.fifo_space} >= NeedSpace;
   assign w_unused_rssi = ^bus.rssi[31:8];

   chan_hdr_build u_pkt_hdr (
      .i_overrun (r_overrun),
      .i_sob     (~r_burst),
      .i_eob     (1'b0),
      .i_len     (PayloadLen),
      .i_rssi    (bus.rssi[7:0]),
      .o_hdr     (w_pkt_hdr)
   );

   chan_hdr_build u_eob_hdr (
      .i_overrun (1'b0),
      .i_sob     (1'b0),
      .i_eob     (1'b1),
      .i_len     (7'd0),
      .i_rssi    (8'd0),
      .o_hdr     (w_eob_hdr)
   );

   // Each word is registered on entry to the state that owns it, so the header
   // appears on the cycle after its strobe.
   always_ff @(posedge i_rx_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= StIdle;
         r_fifodata    <= '0;
         r_hold        <= '0;
         r_ts_latch    <= '0;
         r_wrreq       <= 1'b0;
         r_overrun     <= 1'b0;
         r_burst       <= 1'b0;
         r_eob_pending <= 1'b0;
         r_word_cnt    <= '0;
      end else begin
         r_wrreq <= 1'b0;
         case (r_state)
            StIdle: begin
               if (r_eob_pending || (r_burst && !bus.rx_enable)) begin
                  r_fifodata <= w_eob_hdr;
                  r_wrreq    <= 1'b1;
                  r_state    <= StEobHdr;
               end else if (bus.rx_strobe && bus.rx_enable) begin
                  if (w_has_room) begin
                     r_hold     <= pack_qi16(bus.rx_q, bus.rx_i);
                     r_ts_latch <= bus.timestamp_clock;
                     r_fifodata <= w_pkt_hdr;
                     r_wrreq    <= 1'b1;
                     r_state    <= StHeader;
                  end else begin
                     r_overrun <= 1'b1;
                  end
               end
            end
            StHeader: begin
               r_burst    <= 1'b1;
               r_overrun  <= bus.rx_strobe;  // reported now; a stray strobe re-arms it
               r_fifodata <= r_ts_latch;
               r_wrreq    <= 1'b1;
               r_state    <= StTimestamp;
            end
            StTimestamp: begin
               if (bus.rx_strobe) r_overrun <= 1'b1;
               r_fifodata <= r_hold;
               r_wrreq    <= 1'b1;
               r_word_cnt <= 7'd1;
               r_state    <= StSamples;
            end
            StSamples: begin
               if (r_word_cnt == PayloadLen) begin
                  r_word_cnt <= '0;
                  r_state    <= StIdle;
               end else if (!bus.rx_enable) begin
                  r_fifodata <= '0;
                  r_wrreq    <= 1'b1;
                  r_word_cnt <= r_word_cnt + 7'd1;
                  r_state    <= StPad;
               end else if (bus.rx_strobe) begin
                  r_fifodata <= pack_qi16(bus.rx_q, bus.rx_i);
                  r_wrreq    <= 1'b1;
                  r_word_cnt <= r_word_cnt + 7'd1;
               end
            end
            StPad: begin
               if (r_word_cnt == PayloadLen) begin
                  r_word_cnt    <= '0;
                  r_eob_pending <= 1'b1;
                  r_state       <= StIdle;
               end else begin
                  r_fifodata <= '0;
                  r_wrreq    <= 1'b1;
                  r_word_cnt <= r_word_cnt + 7'd1;
               end
            end
            StEobHdr: begin
               r_burst       <= 1'b0;
               r_eob_pending <= 1'b0;
               r_fifodata    <= bus.timestamp_clock;
               r_wrreq       <= 1'b1;
               r_state       <= StEobTs;
            end
            StEobTs: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign bus.fifodata = r_fifodata;
   assign bus.wrreq    = r_wrreq;
   assign bus.overrun  = r_overrun;
   assign bus.debug    = {4'd0, r_wrreq, r_overrun, r_burst, 4'(r_state), r_word_cnt[3:0]};

endmodule

// File: tb/tb_chan_fifo_writer.sv
// Bench for chan_fifo_writer: vector table, directed corner sequences and
// randomized bursts against a packet-level reference model.
module tb_chan_fifo_writer;

   localparam int unsigned PW = 4;

   logic clk = 1'b0;
   logic rst;

   chan_fifo_writer_if bus ();

   chan_fifo_writer #(
      .PAYLOAD_WORDS (PW)
   ) dut (
      .i_rx_clock (clk),
      .i_reset    (rst),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] got[$];
   logic [31:0] exp_q[$];

   // Reference model state (packet level).
   bit m_open;
   int m_cnt;
   bit m_burst;
   bit m_ovr;

   always @(negedge clk) begin
      if (bus.wrreq === 1'b1) got.push_back(bus.fifodata);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %h required %h", name, act, exp);
   endtask

   function automatic logic [31:0] hdr_word(input bit ovr, input bit sob, input bit eob,
                                            input int len, input logic [7:0] rssi);
      return (32'(ovr) << 31) | (32'(sob) << 28) | (32'(eob) << 27) |
             (32'(rssi) << 16) | (32'(len) << 2);
   endfunction

   task automatic model_reset();
      m_open  = 0;
      m_cnt   = 0;
      m_burst = 0;
      m_ovr   = 0;
      exp_q.delete();
   endtask

   task automatic model_strobe(input logic [15:0] i, input logic [15:0] q, input logic [31:0] ts,
                               input logic [31:0] rssi, input logic [7:0] space);
      if (!m_open) begin
         if (int'(space) >= PW + 2) begin
            exp_q.push_back(hdr_word(m_ovr, !m_burst, 1'b0, PW, rssi[7:0]));
            exp_q.push_back(ts);
            exp_q.push_back({q, i});
            m_burst = 1;
            m_ovr   = 0;
            m_open  = 1;
            m_cnt   = 1;
            if (m_cnt == PW) m_open = 0;
         end else begin
            m_ovr = 1;
         end
      end else begin
         exp_q.push_back({q, i});
         m_cnt++;
         if (m_cnt == PW) m_open = 0;
      end
   endtask

   task automatic model_fall(input logic [31:0] ts);
      if (m_open) begin
         for (int k = m_cnt; k < PW; k++) exp_q.push_back(32'd0);
         m_open = 0;
      end
      if (m_burst) begin
         exp_q.push_back(32'h0800_0000);
         exp_q.push_back(ts);
      end
      m_burst = 0;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      bus.rx_enable  = 1'b0;
      bus.rx_strobe  = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      got.delete();
      model_reset();
   endtask

   // Strobe sampled on the next rising edge; returns 1 time unit after that edge.
   task automatic strobe(input logic [15:0] i, input logic [15:0] q, input logic [31:0] ts,
                         input logic [31:0] rssi, input logic [7:0] space);
      @(posedge clk);
      #1;
      bus.rx_i            = i;
      bus.rx_q            = q;
      bus.timestamp_clock = ts;
      bus.rssi            = rssi;
      bus.fifo_space      = space;
      bus.rx_strobe       = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_strobe = 1'b0;
   endtask

   task automatic fall(input logic [31:0] ts);
      @(posedge clk);
      #1;
      bus.timestamp_clock = ts;
      bus.rx_enable       = 1'b0;
   endtask

   task automatic cmp_stream(input string tag);
      check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < got.size(); k++)
         check($sformatf("%s_w%0d", tag, k), got[k], exp_q[k]);
      got.delete();
      exp_q.delete();
   endtask

   typedef struct {
      logic [7:0]  space;
      logic [31:0] rssi;
      int          nstrobes;
      logic [31:0] exp_hdr0;
      int          exp_words;
      logic        exp_ovr;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [15:0] ri;
      logic [15:0] rq;
      logic [31:0] rts;
      logic [31:0] rrs;
      logic [7:0]  rsp;
      int          ns;
      int          pick;

      vecs[0] = '{8'd255, 32'h0000_005A,  4, 32'h105A_0010,  8, 1'b0};
      vecs[1] = '{8'd6,   32'h0000_0000,  1, 32'h1000_0010,  8, 1'b0};
      vecs[2] = '{8'd5,   32'h0000_0000,  3, 32'h0000_0000,  0, 1'b1};
      vecs[3] = '{8'd255, 32'h0000_0000,  0, 32'h0000_0000,  0, 1'b0};
      vecs[4] = '{8'd255, 32'hFFFF_FF01,  6, 32'h1001_0010, 14, 1'b0};
      vecs[5] = '{8'd255, 32'h0000_0080,  4, 32'h1080_0010,  8, 1'b0};

      bus.rx_enable       = 1'b0;
      bus.rx_strobe       = 1'b0;
      bus.rx_i            = '0;
      bus.rx_q            = '0;
      bus.timestamp_clock = '0;
      bus.rssi            = '0;
      bus.fifo_space      = 8'd255;
      rst                 = 1'b1;
      #12;
      check("rst_fifodata", bus.fifodata, 32'd0);
      check("rst_wrreq", 32'(bus.wrreq), 32'd0);
      check("rst_overrun", 32'(bus.overrun), 32'd0);
      check("rst_debug", 32'(bus.debug), 32'd0);
      do_reset();

      // Two packets then burst end with padding.
      bus.rx_enable = 1'b1;
      for (int k = 0; k < 6; k++) begin
         strobe(16'(k + 1), 16'(16'h10 + k), 32'(100 + k), 32'h5A, 8'd255);
         if (k == 0) begin
            check("tp1_hdr_latency_wrreq", 32'(bus.wrreq), 32'd1);
            check("tp1_hdr_latency_data", bus.fifodata, 32'h105A_0010);
         end
         repeat (3) @(posedge clk);
      end
      fall(32'h200);
      repeat (PW + 10) @(posedge clk);
      #1;
      exp_q = '{32'h105A_0010, 32'd100, 32'h0010_0001, 32'h0011_0002, 32'h0012_0003,
                32'h0013_0004, 32'h005A_0010, 32'd104, 32'h0014_0005, 32'h0015_0006,
                32'd0, 32'd0, 32'h0800_0000, 32'h200};
      cmp_stream("tp12");

      // No room at first strobe, then overrun reported in the next header.
      do_reset();
      bus.rx_enable = 1'b1;
      strobe(16'd1, 16'd2, 32'd7, 32'h5A, 8'd3);
      repeat (3) @(posedge clk);
      #1;
      check("ovr_no_writes", 32'(got.size()), 32'd0);
      check("ovr_sticky", 32'(bus.overrun), 32'd1);
      strobe(16'd3, 16'd4, 32'd8, 32'h5A, 8'd255);
      check("ovr_hdr", bus.fifodata, 32'h905A_0010);
      check("ovr_during_hdr", 32'(bus.overrun), 32'd1);
      @(posedge clk);
      #1;
      check("ovr_cleared", 32'(bus.overrun), 32'd0);

      // Enable drops in the cycle the last sample is written: no pad.
      do_reset();
      bus.rx_enable = 1'b1;
      for (int k = 0; k < 4; k++) begin
         strobe(16'(k + 1), 16'(16'h10 + k), 32'd50, 32'h0, 8'd255);
         if (k < 3) repeat (3) @(posedge clk);
      end
      check("bnd_last_wr", 32'(bus.wrreq), 32'd1);
      bus.timestamp_clock = 32'h77;
      bus.rx_enable       = 1'b0;
      repeat (PW + 10) @(posedge clk);
      #1;
      check("bnd_len", 32'(got.size()), 32'd8);
      if (got.size() == 8) begin
         check("bnd_last_sample", got[5], 32'h0013_0004);
         check("bnd_eob_hdr", got[6], 32'h0800_0000);
         check("bnd_eob_ts", got[7], 32'h77);
      end

      // Stray strobe in HEADER, then async reset mid-SAMPLES.
      do_reset();
      bus.rx_enable = 1'b1;
      strobe(16'd1, 16'd2, 32'd9, 32'h0, 8'd255);
      bus.rx_strobe = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_strobe = 1'b0;
      check("hdr_strobe_ovr", 32'(bus.overrun), 32'd1);
      @(posedge clk);
      #3;
      check("pre_rst_wrreq", 32'(bus.wrreq), 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_wrreq", 32'(bus.wrreq), 32'd0);
      check("async_rst_ovr", 32'(bus.overrun), 32'd0);
      check("async_rst_debug", 32'(bus.debug), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      got.delete();
      strobe(16'd5, 16'd6, 32'd11, 32'h33, 8'd255);
      check("post_rst_sob_hdr", bus.fifodata, 32'h1033_0010);
      do_reset();

      // Enable toggled with no strobes.
      for (int k = 0; k < 3; k++) begin
         bus.rx_enable = 1'b1;
         repeat (5) @(posedge clk);
         #1;
         bus.rx_enable = 1'b0;
         repeat (5) @(posedge clk);
      end
      #1;
      check("toggle_no_writes", 32'(got.size()), 32'd0);

      // Vector table: one burst per entry.
      for (int v = 0; v < 6; v++) begin
         do_reset();
         bus.rx_enable = 1'b1;
         for (int k = 0; k < vecs[v].nstrobes; k++) begin
            strobe(16'(k + 1), 16'(16'h10 + k), 32'(200 + k), vecs[v].rssi, vecs[v].space);
            repeat (3) @(posedge clk);
         end
         fall(32'h300);
         repeat (PW + 10) @(posedge clk);
         #1;
         check($sformatf("vec%0d_words", v), 32'(got.size()), 32'(vecs[v].exp_words));
         check($sformatf("vec%0d_ovr", v), 32'(bus.overrun), 32'(vecs[v].exp_ovr));
         if (vecs[v].exp_words > 0 && got.size() > 0)
            check($sformatf("vec%0d_hdr", v), got[0], vecs[v].exp_hdr0);
      end

      // Randomized bursts against the reference model; state carries across bursts.
      do_reset();
      for (int b = 0; b < 30; b++) begin
         ns = $urandom_range(0, 10);
         bus.rx_enable = 1'b1;
         repeat (2) @(posedge clk);
         for (int s = 0; s < ns; s++) begin
            ri   = 16'($urandom);
            rq   = 16'($urandom);
            rts  = $urandom;
            rrs  = $urandom;
            pick = $urandom_range(0, 5);
            if (pick == 0) rsp = 8'd3;
            else if (pick == 1) rsp = 8'(PW + 1);
            else if (pick == 2) rsp = 8'(PW + 2);
            else rsp = 8'($urandom_range(7, 255));
            strobe(ri, rq, rts, rrs, rsp);
            model_strobe(ri, rq, rts, rrs, rsp);
            repeat ($urandom_range(3, 6)) @(posedge clk);
         end
         rts = $urandom;
         fall(rts);
         model_fall(rts);
         repeat (PW + 10) @(posedge clk);
         #1;
         cmp_stream($sformatf("rnd%0d", b));
         check($sformatf("rnd%0d_ovr", b), 32'(bus.overrun), 32'(m_ovr));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/chan_fifo_writer.md
Name: chan_fifo_writer

Overview:
- Receive-side counterpart of the channel FIFO reader.
- Takes decimated rx samples from the rx chain on rx_strobe and frames them into fixed-length packets: header word, timestamp word, then PAYLOAD_WORDS sample words.
- Writes the packets into the per-channel FIFO that the USB packer drains.
- Flags overruns when the FIFO lacks room, and marks burst start and end in the header.

Parameters:
- PAYLOAD_WORDS, 126, sample words per packet; range 1..127 so it fits header bits 8:2.

Ports:
- rx_clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- rx_enable  in  1  high while the channel is receiving; a rising edge starts a burst, a falling edge ends it
- rx_strobe  in  1  one-cycle sample-valid; at least 4 rx_clock cycles between strobes
- rx_i  in  16  I sample, valid on rx_strobe
- rx_q  in  16  Q sample, valid on rx_strobe
- timestamp_clock  in  32  current time
- rssi  in  32  channel RSSI; bits 7:0 go into the header
- fifo_space  in  8  free words in the downstream FIFO
- fifodata  out  32  word to write
- wrreq  out  1  write strobe, one cycle per word
- overrun  out  1  sticky overrun indicator
- debug  out  15  {4'd0, wrreq, overrun, burst, state[3:0], word_cnt[3:0]}; burst and state are the internal burst register and FSM state

Behaviour:
Reset values:
- state IDLE; fifodata 0; wrreq 0; overrun 0; burst 0; word_cnt 0; end marker pending 0.

Header format (shared with reader):
- 31 OVERRUN, 28 STARTOFBURST, 27 ENDOFBURST, 23:16 rssi[7:0], 8:2 payload length. All other bits 0.

Registered write path:
- wrreq and fifodata are registered; each is asserted exactly one cycle per word.

States:
- IDLE
  - rx_strobe with rx_enable=1 and fifo_space >= PAYLOAD_WORDS+2: latch rx_i/rx_q into the hold register and timestamp_clock into ts_latch; go to HEADER.
  - rx_strobe with rx_enable=1 and insufficient space: drop the sample and set overrun<=1.
  - End marker pending (rx_enable fell on a packet boundary or during PAD): go to EOB_HDR.
- HEADER
  - Write the header: len=PAYLOAD_WORDS, STARTOFBURST=~burst, OVERRUN=overrun, rssi.
  - burst<=1; overrun<=0 (cleared once reported); go to TIMESTAMP.
- TIMESTAMP
  - Write ts_latch; go to SAMPLES with a held-sample-pending flag set.
- SAMPLES
  - The held sample is written the cycle after TIMESTAMP.
  - Afterwards, each rx_strobe writes {rx_q, rx_i} (Q in 31:16, I in 15:0) on the next cycle; word_cnt increments per sample word.
  - When word_cnt reaches PAYLOAD_WORDS: go to IDLE, word_cnt<=0.
  - If rx_enable is 0 while word_cnt < PAYLOAD_WORDS: go to PAD.
- PAD
  - Write 32'd0 every cycle until word_cnt reaches PAYLOAD_WORDS, so the packet length always matches its header.
  - Then set end marker pending and go to IDLE.
- EOB_HDR
  - Write header with len=0, ENDOFBURST=1, STARTOFBURST=0.
  - burst<=0; clear the end marker; go to EOB_TS.
  - Does not wait on fifo_space: PAYLOAD_WORDS+2 space was reserved at packet start, and the 2-word marker is guaranteed by the FIFO sizing rule (depth >= 2*(PAYLOAD_WORDS+2)).
- EOB_TS
  - Write timestamp_clock; go to IDLE.

Boundary conditions:
- rx_enable falling exactly when word_cnt reaches PAYLOAD_WORDS: no PAD; the end marker follows the full packet.
- rx_enable falling in IDLE with burst=1: end marker written. With burst=0: nothing written.
- rx_strobe during HEADER or TIMESTAMP: impossible under the strobe spacing rule; if it occurs, the sample is dropped and overrun<=1.
- Overrun persists across packets until a header carries it.
- 32-bit timestamp wraps naturally; no special handling.
- Reset mid-packet: everything returns to reset values immediately; a partial packet left in the FIFO is the FIFO owner's responsibility (the FIFO is reset together with the writer).
- Latency: header written 1 cycle after the first accepted strobe; each subsequent sample is written 1 cycle after its strobe.

Decomposition:
- Shared package: header bit-position constants (PAYLOAD 8:2, ENDOFBURST 27, STARTOFBURST 28, OVERRUN 31, RSSI 23:16), sample format code QI16, state encodings. The reader uses the same constants.
- Sub-module: chan_hdr_build, a combinational header word assembly from flags, length and rssi. The FSM stays in the top module.

Test Plan:
- PAYLOAD_WORDS=4, fifo_space=255, rx_enable high, 4 strobes (I=1..4, Q=0x10..0x13), timestamp_clock=100 at first strobe -> words 0x1000_0010 | rssi<<16, 100, 0x0010_0001 .. 0x0013_0004.
- Same setup, 6 strobes then rx_enable low -> second packet: STARTOFBURST=0, 2 samples, 2 zero pad words, then EOB header 0x0800_0000 and a timestamp.
- fifo_space=3 at the first strobe -> no wrreq, overrun=1. Raise space; next strobe -> header bit 31 set, overrun cleared the cycle after the header.
- rx_enable drops in the same cycle the 4th sample is written -> no pad words; the EOB marker follows immediately.
- Assert reset asynchronously mid-SAMPLES -> wrreq=0 and overrun=0 without waiting for a clock edge. After release, a new strobe produces STARTOFBURST=1.
- rx_enable toggled with no strobes -> zero writes.
